bus_request_controller: RTL and testbench

- Per-master front end that sits directly upstream of the bus arbiter, one instance per device.
- Converts a device's "start burst" command into the arbiter request signal and holds ownership for an N-beat burst.
- Handles preemption by higher-priority masters, a grant timeout, and a post-burst hold-off. The hold-off stops a low-index master from starving others under fixed-priority arbitration.

---
 rtl/bus_request_controller_if.sv | 27 ++
 rtl/bus_request_controller.sv | 154 +++++++++++++++
 tb/tb_bus_request_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_request_controller_if.sv
// Handshake bundle between a bus device, its request controller and the arbiter.
// The master modport is the device/arbiter side; the slave modport is the controller.
interface bus_request_controller_if #(
    parameter int BURST_WIDTH = 4
);
    logic                   start;
    logic [BURST_WIDTH-1:0] burst_length;
    logic                   busy;
    logic                   request;
    logic                   grant;
    logic                   beat_valid;
    logic                   beat_ready;
    logic [BURST_WIDTH-1:0] beat_index;
    logic                   done;
    logic                   preempted;
    logic                   timeout;

    modport master (
        output start, burst_length, grant, beat_ready,
        input  busy, request, beat_valid, beat_index, done, preempted, timeout
    );

    modport slave (
        input  start, burst_length, grant, beat_ready,
        output busy, request, beat_valid, beat_index, done, preempted, timeout
    );
endinterface

// File: rtl/bus_request_controller.sv
// Per-master front end to the bus arbiter: turns a burst command into a held request,
// tracks beats, resumes after preemption, gives up on grant timeout and backs off afterwards.
module bus_request_controller #(
    parameter int BURST_WIDTH     = 4,
    parameter int HOLD_OFF_CYCLES = 2,
    parameter int GRANT_TIMEOUT   = 16
) (
    input logic                     clock,
    input logic                     reset,
    bus_request_controller_if.slave bus
);

    localparam int WAIT_W     = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam int HOLD_W     = (HOLD_OFF_CYCLES > 1) ? $clog2(HOLD_OFF_CYCLES) : 1;
    localparam int HOLD_LAST_I = (HOLD_OFF_CYCLES > 0) ? HOLD_OFF_CYCLES - 1 : 0;

    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(GRANT_TIMEOUT);
    localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HOLD_LAST_I);
    localparam logic [BURST_WIDTH-1:0] BEAT_ONE   = BURST_WIDTH'(1);
    localparam logic [WAIT_W-1:0]      WAIT_ONE   = WAIT_W'(1);
    localparam logic [HOLD_W-1:0]      HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_OWN,
        S_HOLD_OFF
    } state_e;

    state_e                 state_q,      state_d;
    logic [BURST_WIDTH-1:0] beat_index_q, beat_index_d;
    logic [BURST_WIDTH-1:0] last_idx_q,   last_idx_d;
    logic [WAIT_W-1:0]      wait_q,       wait_d;
    logic [HOLD_W-1:0]      hold_q,       hold_d;
    logic                   request_q,    request_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   preempted_q,  preempted_d;
    logic                   timeout_q,    timeout_d;
    logic [WAIT_W-1:0]      wait_inc;

    assign wait_inc = wait_q + WAIT_ONE;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        beat_index_d = beat_index_q;
        last_idx_d   = last_idx_q;
        wait_d       = wait_q;
        hold_d       = hold_q;
        done_d       = 1'b0;
        preempted_d  = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // A zero length is a single-beat burst, so the last index is 0 either way.
                    last_idx_d   = (bus.burst_length == '0) ? '0 : bus.burst_length - BEAT_ONE;
                    beat_index_d = '0;
                    wait_d       = '0;
                    state_d      = S_REQUEST;
                end
            end

            S_REQUEST: begin
                if (bus.grant) begin
                    state_d = S_OWN;
                end else if (GRANT_TIMEOUT > 0) begin
                    if (wait_inc == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                        hold_d    = '0;
                        state_d   = S_HOLD_OFF;
                    end else begin
                        wait_d = wait_inc;
                    end
                end
            end

            S_OWN: begin
                if (!bus.grant) begin
                    // Beat position is kept so the burst resumes where it was cut off.
                    preempted_d = 1'b1;
                    wait_d      = '0;
                    state_d     = S_REQUEST;
                end else if (bus.beat_ready) begin
                    if (beat_index_q == last_idx_q) begin
                        beat_index_d = '0;
                        done_d       = 1'b1;
                        hold_d       = '0;
                        state_d      = S_HOLD_OFF;
                    end else begin
                        beat_index_d = beat_index_q + BEAT_ONE;
                    end
                end
            end

            S_HOLD_OFF: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        request_d = (state_d == S_REQUEST) || (state_d == S_OWN);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_index_q <= '0;
            last_idx_q   <= '0;
            wait_q       <= '0;
            hold_q       <= '0;
            request_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            preempted_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_index_q <= beat_index_d;
            last_idx_q   <= last_idx_d;
            wait_q       <= wait_d;
            hold_q       <= hold_d;
            request_q    <= request_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            preempted_q  <= preempted_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.request    = request_q;
    assign bus.busy       = busy_q;
    assign bus.beat_valid = (state_q == S_OWN) && bus.grant;
    assign bus.beat_index = beat_index_q;
    assign bus.done       = done_q;
    assign bus.preempted  = preempted_q;
    assign bus.timeout    = timeout_q;

    pulses_exclusive: assert property (@(posedge clock) disable iff (!reset)
        $onehot0({done_q, preempted_q, timeout_q}));

    valid_needs_request: assert property (@(posedge clock) disable iff (!reset)
        bus.beat_valid |-> request_q);

endmodule

// File: tb/tb_bus_request_controller.sv
// Randomised and directed stimulus against a burst-level reference model; beat and pulse
// expectations are queued by the driver and consumed by an independent monitor.
module tb_bus_request_controller;

    localparam int BW   = 4;
    localparam int HOLD = 2;
    localparam int TMO  = 16;

    typedef enum int {EV_DONE, EV_PREEMPT, EV_TIMEOUT} ev_e;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bus_request_controller_if #(.BURST_WIDTH(BW)) bif ();

    bus_request_controller #(
        .BURST_WIDTH    (BW),
        .HOLD_OFF_CYCLES(HOLD),
        .GRANT_TIMEOUT  (TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    int  checks = 0;
    int  errors = 0;
    int  exp_beat_q[$];
    ev_e exp_ev_q[$];

    // Reference model: a burst in flight, whether the bus is held, progress and back-off.
    bit m_active = 0;
    bit m_own    = 0;
    int m_idx    = 0;
    int m_len    = 1;
    int m_starve = 0;
    int m_cool   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_v, input bit st, input int bl, input bit g, input bit rdy);
        @(negedge clock);
        reset             = rst_v;
        bif.start         = st;
        bif.burst_length  = bl[BW-1:0];
        bif.grant         = g;
        bif.beat_ready    = rdy;
        #1;
        check("request", bif.request, m_active);
        check("busy", bif.busy, m_active || (m_cool > 0));
        check("beat_valid", bif.beat_valid, m_own && g);
        if (m_own && g) check("beat_index", bif.beat_index, m_idx);

        if (!rst_v) begin
            m_active = 0; m_own = 0; m_idx = 0; m_starve = 0; m_cool = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_own = 0; m_idx = 0; m_starve = 0;
                m_len = (bl[BW-1:0] == 0) ? 1 : int'(bl[BW-1:0]);
            end
        end else if (!m_own) begin
            if (g) begin
                m_own = 1;
            end else begin
                m_starve++;
                if (TMO > 0 && m_starve == TMO) begin
                    exp_ev_q.push_back(EV_TIMEOUT);
                    m_active = 0;
                    m_cool   = (HOLD > 0) ? HOLD : 1;
                end
            end
        end else if (!g) begin
            exp_ev_q.push_back(EV_PREEMPT);
            m_own    = 0;
            m_starve = 0;
        end else if (rdy) begin
            exp_beat_q.push_back(m_idx);
            if (m_idx == m_len - 1) begin
                exp_ev_q.push_back(EV_DONE);
                m_idx = 0; m_active = 0; m_own = 0;
                m_cool = (HOLD > 0) ? HOLD : 1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, 1);
    endtask

    // Monitor: consumes expectations whenever the DUT shows a transfer or a pulse.
    initial begin
        ev_e obs;
        forever begin
            @(negedge clock);
            #2;
            if (reset === 1'b1 && bif.beat_valid === 1'b1 && bif.beat_ready === 1'b1) begin
                if (exp_beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got index %0d expected no transfer (t=%0t)",
                             bif.beat_index, $time);
                end else begin
                    check("beat_order", bif.beat_index, exp_beat_q.pop_front());
                end
            end
            if ($countones({bif.done, bif.preempted, bif.timeout}) > 1) begin
                checks++; errors++;
                $display("FAIL pulse_exclusive: got %b expected at most one pulse (t=%0t)",
                         {bif.done, bif.preempted, bif.timeout}, $time);
            end else if (bif.done === 1'b1 || bif.preempted === 1'b1 || bif.timeout === 1'b1) begin
                obs = bif.done ? EV_DONE : (bif.preempted ? EV_PREEMPT : EV_TIMEOUT);
                if (exp_ev_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse_unexpected: got %s expected none (t=%0t)", obs.name(), $time);
                end else begin
                    check("pulse_kind", obs, exp_ev_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit rst_v, g;
        int outage;
        bif.start = 0; bif.burst_length = '0; bif.grant = 0; bif.beat_ready = 0;
        reset = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_request", bif.request, 0);
        check("reset_busy", bif.busy, 0);
        check("reset_done", bif.done, 0);
        check("reset_preempted", bif.preempted, 0);
        check("reset_timeout", bif.timeout, 0);
        check("reset_beat_index", bif.beat_index, 0);

        // Basic burst of 3 with grant tied high, then a second burst after the hold-off.
        step(1, 1, 3, 1, 1);
        idle(8);
        step(1, 1, 1, 1, 1);
        idle(5);

        // Reset after two accepted beats of a 4-beat burst.
        step(1, 1, 4, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        check("rst_mid_request", bif.request, 0);
        check("rst_mid_busy", bif.busy, 0);
        check("rst_mid_index", bif.beat_index, 0);
        check("rst_mid_done", bif.done, 0);
        idle(3);

        // Backpressure: beat 0 stalled for three cycles.
        step(1, 1, 2, 1, 1);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        idle(4);

        // Preemption after beat 1, grant lost for two cycles, then resume.
        step(1, 1, 4, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);
        idle(4);

        // Grant never arrives: timeout, then hold-off.
        step(1, 1, 3, 0, 1);
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 1);
        idle(2);

        // Zero length means one beat.
        step(1, 1, 0, 1, 1);
        idle(6);

        // start held high through an entire burst and its hold-off.
        for (int i = 0; i < 7; i++) step(1, 1, 3, 1, 1);
        idle(4);

        // Randomised traffic with occasional grant outages and resets.
        outage = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_v = ($urandom_range(0, 599) != 0);
            if (outage == 0 && $urandom_range(0, 149) == 0) outage = $urandom_range(10, 24);
            g = (outage > 0) ? 1'b0 : ($urandom_range(0, 9) < 8);
            if (outage > 0) outage--;
            step(rst_v, $urandom_range(0, 3) == 0, $urandom_range(0, 15), g,
                 $urandom_range(0, 9) < 7);
        end

        idle(30);
        #3;
        check("beat_queue_drained", exp_beat_q.size(), 0);
        check("pulse_queue_drained", exp_ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
